// File: rtl/dig_clkdiv_bank.sv
// ---------------------------------------------------------------------------
// dig_clkdiv_bank
//
// Bank of NCH independent programmable clock dividers, all running from one
// master clock. Each channel produces a registered divided square wave
// (div_out) and a gated clock (cclk) that carries exactly one clk-high phase
// per divided period. It is intended to clock a cochlea core.
//
// All state changes happen on the falling edge of clk. The gate therefore
// only moves while clk is low, and cclk = gate & clk cannot glitch.
//
// Ratio and enable changes are staged in a per-channel pending slot. A running
// channel picks the change up only at its wrap edge, so the period in flight
// always completes at the old ratio. A disabled channel picks it up on the
// next falling edge. The sync strobe forces every pending change in at once
// and parks all counters at zero, so enabled channels restart phase-aligned.
//
// Ports
//   clk        master clock (state updates on negedge)
//   rstb       asynchronous active-low reset
//   sync       phase-align strobe, sampled on negedge
//   cfg_valid  config write request
//   cfg_ready  config write can be accepted (combinational)
//   cfg_ch     target channel; values >= NCH are accepted and dropped
//   cfg_div    new ratio N; 0 and 1 are clamped to 2
//   cfg_en     new channel enable
//   div_out    divided clock per channel (registered)
//   cclk       gated clock per channel: gate & clk
// ---------------------------------------------------------------------------
module dig_clkdiv_bank #(
    parameter  int NCH    = 4,
    parameter  int CNTW   = 8,
    parameter  int RST_EN = 1,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CNTW-1:0]   cfg_div,
    input  logic              cfg_en,
    output logic [NCH-1:0]    div_out,
    output logic [NCH-1:0]    cclk
);

    // Live per-channel state
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic [CNTW-1:0] n_q   [NCH];
    logic [CNTW-1:0] n_d   [NCH];
    logic [NCH-1:0]  en_q, en_d;
    logic [NCH-1:0]  gate_q, gate_d;
    logic [NCH-1:0]  div_q, div_d;

    // Staged configuration waiting for its apply point
    logic [CNTW-1:0] pn_q  [NCH];
    logic [CNTW-1:0] pn_d  [NCH];
    logic [NCH-1:0]  pen_q, pen_d;
    logic [NCH-1:0]  pend_q, pend_d;

    // Helpers for counting and config acceptance
    logic [CNTW-1:0] cnt_nx   [NCH];
    logic [CNTW-1:0] n_last   [NCH];
    logic [NCH-1:0]  wrap;
    logic [NCH-1:0]  cfg_sel;
    logic [CNTW-1:0] cfg_div_cl;

    // A ratio below 2 has no low phase, so 0 and 1 are clamped to 2.
    always_comb begin
        cfg_div_cl = cfg_div;
        if (cfg_div < CNTW'(2)) begin
            cfg_div_cl = CNTW'(2);
        end
    end

    // The pending flag only blocks writes to its own channel. An out-of-range
    // channel matches nothing, so it reads ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        cfg_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(cfg_ch) == 32'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            cfg_sel[i] = cfg_valid & cfg_ready & (32'(cfg_ch) == 32'(i));
        end
    end

    // Wrap detection and the free-running next count per channel
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NCH; i++) begin
            n_last[i] = n_q[i] - CNTW'(1);
            wrap[i]   = (cnt_q[i] == n_last[i]);
            cnt_nx[i] = wrap[i] ? '0 : cnt_q[i] + CNTW'(1);
        end
    end

    // Next-state per channel. Sync has priority over counting. The apply
    // test uses the pending flag from before this edge. A write accepted on
    // a wrap or sync edge is therefore only staged here and applied at the
    // following apply point.
    always_comb begin
        en_d   = en_q;
        gate_d = gate_q;
        div_d  = div_q;
        pen_d  = pen_q;
        pend_d = pend_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            n_d[i]   = n_q[i];
            pn_d[i]  = pn_q[i];

            if (sync) begin
                if (pend_q[i]) begin
                    n_d[i]    = pn_q[i];
                    en_d[i]   = pen_q[i];
                    pend_d[i] = 1'b0;
                end
                cnt_d[i]  = '0;
                div_d[i]  = 1'b0;
                gate_d[i] = 1'b0;
            end else if (en_q[i]) begin
                // At the wrap cnt_nx is 0. This gives div=0 and gate=0 for
                // any N >= 2, so applying a new ratio here is runt-free.
                cnt_d[i]  = cnt_nx[i];
                div_d[i]  = (cnt_nx[i] >= (n_q[i] >> 1));
                gate_d[i] = (cnt_nx[i] == n_last[i]);
                if (wrap[i] && pend_q[i]) begin
                    n_d[i]    = pn_q[i];
                    en_d[i]   = pen_q[i];
                    pend_d[i] = 1'b0;
                end
            end else begin
                // Parked channel: hold at zero and take any staged config now.
                if (pend_q[i]) begin
                    n_d[i]    = pn_q[i];
                    en_d[i]   = pen_q[i];
                    pend_d[i] = 1'b0;
                end
                cnt_d[i]  = '0;
                div_d[i]  = 1'b0;
                gate_d[i] = 1'b0;
            end

            if (cfg_sel[i]) begin
                pn_d[i]   = cfg_div_cl;
                pen_d[i]  = cfg_en;
                pend_d[i] = 1'b1;
            end
        end
    end

    // Falling-edge state register with asynchronous active-low reset
    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            en_q   <= {NCH{(RST_EN != 0)}};
            gate_q <= '0;
            div_q  <= '0;
            pen_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                n_q[i]   <= CNTW'(2);
                pn_q[i]  <= CNTW'(2);
            end
        end else begin
            en_q   <= en_d;
            gate_q <= gate_d;
            div_q  <= div_d;
            pen_q  <= pen_d;
            pend_q <= pend_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                n_q[i]   <= n_d[i];
                pn_q[i]  <= pn_d[i];
            end
        end
    end

    assign div_out = div_q;
    assign cclk    = gate_q & {NCH{clk}};

endmodule

// File: tb/tb_dig_clkdiv_bank.sv
// ---------------------------------------------------------------------------
// tb_dig_clkdiv_bank
//
// Directed bench for dig_clkdiv_bank with NCH=4, CNTW=8 and RST_EN=1.
//
// Each stimulus vector is driven in the clk-high phase and carries the
// expected outputs for that cycle. The expected values are div_out, cclk
// while clk is high (equal to the gate), and cfg_ready for the inputs on the
// pins. These outputs reflect the falling edge just before the vector. The
// inputs themselves are sampled at the falling edge that follows it.
//
// A monitor samples the outputs late in the high phase and checks them
// against a queue of expected values. A second checker requires cclk to be
// 0 throughout every clk-low phase.
//
// Bit order of the 4-bit expectations is {ch3, ch2, ch1, ch0}.
// ---------------------------------------------------------------------------
module tb_dig_clkdiv_bank;

    localparam int NCH  = 4;
    localparam int CNTW = 8;
    localparam int CHW  = 2;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [CNTW-1:0]  cfg_div = '0;
    logic             cfg_en = 1'b0;
    logic [NCH-1:0]   div_out;
    logic [NCH-1:0]   cclk;

    typedef struct {
        logic [3:0] div;
        logic [3:0] ck;
        logic       rdy;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_num = 0;

    dig_clkdiv_bank #(.NCH(NCH), .CNTW(CNTW), .RST_EN(1)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .div_out   (div_out),
        .cclk      (cclk)
    );

    // 10 ns master clock. Rising edges fall at 5, 15, ... and falling
    // edges at 10, 20, ...
    always #5 clk = ~clk;

    // Single comparison point. Every check goes through here.
    task automatic checkOutput(input string name, input int vec,
                               input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s vec=%0d actual=%b expected=%b", name, vec, act, expv);
        end
    endtask

    // Drive one cycle of inputs in the high phase and queue what the monitor
    // must see in that same high phase.
    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input int ch, input int dv, input logic e,
                                 input logic [3:0] ediv, input logic [3:0] eck,
                                 input logic erdy);
        exp_t x;
        @(posedge clk);
        #2;
        rstb      = r;
        sync      = s;
        cfg_valid = v;
        cfg_ch    = CHW'(ch);
        cfg_div   = CNTW'(dv);
        cfg_en    = e;
        x.div = ediv;
        x.ck  = eck;
        x.rdy = erdy;
        x.idx = vec_num;
        vec_num++;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor. It samples 1 ns before the falling edge and
    // compares against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("div_out", e.idx, div_out, e.div);
                checkOutput("cclk_high", e.idx, cclk, e.ck);
                checkOutput("cfg_ready", e.idx, {3'b000, cfg_ready}, {3'b000, e.rdy});
            end
        end
    end

    // The gated clock must never be high while clk is low.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checkOutput("cclk_low", -1, cclk, 4'b0000);
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Hold reset for two cycles. Vector 0 then releases it in the
        // high phase, so the next falling edge is the first active edge.
        repeat (2) @(posedge clk);

        // Reset release and default div-by-2 on all channels
        applyStimulus(1,0,0,0,0,0, 4'b0000,4'b0000,1);   // v0
        applyStimulus(1,0,0,0,0,0, 4'b1111,4'b1111,1);   // v1
        applyStimulus(1,0,0,0,0,0, 4'b0000,4'b0000,1);   // v2

        // ch1 -> N=5 on its wrap edge (staged), then ch2 -> N=3.
        // Both apply at the next common wrap.
        applyStimulus(1,0,1,1,5,1, 4'b1111,4'b1111,1);   // v3
        applyStimulus(1,0,1,2,3,1, 4'b0000,4'b0000,1);   // v4
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1111,0);   // v5
        applyStimulus(1,0,0,1,0,0, 4'b0000,4'b0000,1);   // v6
        applyStimulus(1,0,0,1,0,0, 4'b1101,4'b1001,1);   // v7
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0100,1);   // v8
        applyStimulus(1,0,0,1,0,0, 4'b1011,4'b1001,1);   // v9
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0010,1);   // v10
        applyStimulus(1,0,0,1,0,0, 4'b1101,4'b1101,1);   // v11
        applyStimulus(1,0,0,1,0,0, 4'b0000,4'b0000,1);   // v12

        // Mid-period change: ch1 at cnt=2 of N=5 goes to N=4.
        // The 5-cycle period completes before the new ratio takes effect.
        applyStimulus(1,0,1,1,4,1, 4'b1111,4'b1001,1);   // v13
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0100,0);   // v14
        applyStimulus(1,0,0,1,0,0, 4'b1011,4'b1011,0);   // v15
        applyStimulus(1,0,0,1,0,0, 4'b0100,4'b0000,1);   // v16
        applyStimulus(1,0,0,1,0,0, 4'b1101,4'b1101,1);   // v17
        applyStimulus(1,0,0,1,0,0, 4'b0010,4'b0000,1);   // v18
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1011,1);   // v19
        applyStimulus(1,0,0,1,0,0, 4'b0100,4'b0100,1);   // v20
        applyStimulus(1,0,0,1,0,0, 4'b1001,4'b1001,1);   // v21
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0000,1);   // v22

        // Write ch1 N=3 on its wrap edge. A second write (N=6) is held
        // off until the first one applies one full N=4 period later.
        applyStimulus(1,0,1,1,3,1, 4'b1111,4'b1111,1);   // v23
        applyStimulus(1,0,1,1,6,1, 4'b0000,4'b0000,0);   // v24
        applyStimulus(1,0,1,1,6,1, 4'b1101,4'b1001,0);   // v25
        applyStimulus(1,0,1,1,6,1, 4'b0110,4'b0100,0);   // v26
        applyStimulus(1,0,1,1,6,1, 4'b1011,4'b1011,0);   // v27
        applyStimulus(1,0,1,1,6,1, 4'b0100,4'b0000,1);   // v28
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1101,0);   // v29
        applyStimulus(1,0,0,1,0,0, 4'b0010,4'b0010,0);   // v30
        applyStimulus(1,0,0,1,0,0, 4'b1101,4'b1001,1);   // v31
        applyStimulus(1,0,0,1,0,0, 4'b0100,4'b0100,1);   // v32
        applyStimulus(1,0,0,1,0,0, 4'b1001,4'b1001,1);   // v33
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0000,1);   // v34
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1101,1);   // v35
        applyStimulus(1,0,0,1,0,0, 4'b0010,4'b0010,1);   // v36

        // Clamp: ch2 cfg_div=0 gives N=2. Disable: ch1 parks at the end
        // of its N=6 period. Re-enable ch1 with cfg_div=1 (clamps to 2),
        // which restarts with cnt=1.
        applyStimulus(1,0,1,2,0,1, 4'b1101,4'b1001,1);   // v37
        applyStimulus(1,0,1,1,7,0, 4'b0100,4'b0100,1);   // v38
        applyStimulus(1,0,0,1,0,0, 4'b1001,4'b1001,0);   // v39
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0100,0);   // v40
        applyStimulus(1,0,0,1,0,0, 4'b1011,4'b1001,0);   // v41
        applyStimulus(1,0,0,1,0,0, 4'b0110,4'b0110,0);   // v42
        applyStimulus(1,0,0,1,0,0, 4'b1001,4'b1001,1);   // v43
        applyStimulus(1,0,1,1,1,1, 4'b0100,4'b0100,1);   // v44
        applyStimulus(1,0,0,1,0,0, 4'b1001,4'b1001,0);   // v45
        applyStimulus(1,0,0,1,0,0, 4'b0100,4'b0100,1);   // v46

        // Set up ch1=3, ch2=4, ch3=5 (ch0 stays 2), then sync. The ch0
        // write on the sync edge is only staged.
        applyStimulus(1,0,1,1,3,1, 4'b1011,4'b1011,1);   // v47
        applyStimulus(1,0,1,2,4,1, 4'b0100,4'b0100,1);   // v48
        applyStimulus(1,0,1,3,5,1, 4'b1011,4'b1011,1);   // v49
        applyStimulus(1,1,1,0,2,1, 4'b0100,4'b0100,1);   // v50
        applyStimulus(1,0,0,0,0,0, 4'b0000,4'b0000,0);   // v51
        applyStimulus(1,0,0,0,0,0, 4'b0011,4'b0001,0);   // v52
        applyStimulus(1,0,0,0,0,0, 4'b1110,4'b0010,1);   // v53
        applyStimulus(1,0,0,0,0,0, 4'b1101,4'b0101,1);   // v54

        // Stage a ch1 write, then assert reset while clk is high and cclk
        // is pulsing. Outputs and pending state must clear at once.
        applyStimulus(1,0,1,1,7,1, 4'b1010,4'b1000,1);   // v55
        applyStimulus(0,0,0,1,0,0, 4'b0000,4'b0000,1);   // v56
        applyStimulus(0,0,0,1,0,0, 4'b0000,4'b0000,1);   // v57

        // After reset every channel is back to div-by-2.
        applyStimulus(1,0,0,1,0,0, 4'b0000,4'b0000,1);   // v58
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1111,1);   // v59
        applyStimulus(1,0,0,1,0,0, 4'b0000,4'b0000,1);   // v60
        applyStimulus(1,0,0,1,0,0, 4'b1111,4'b1111,1);   // v61

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #5;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
